alu: RTL and testbench



---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_shifter.sv | 19 +
 rtl/alu.sv | 55 +++++
 tb/tb_alu.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op-code definitions for the datapath ALU and the control unit that drives it.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_LUI = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

endpackage

// File: rtl/alu_shifter.sv
// Combinational logical shifter for SLL/SRL; zero fill in both directions.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [31:0] b_i,
  input  logic [4:0]  s_i,
  input  logic        dir_i,
  output logic [31:0] y_o
);

  always_comb begin
    if (dir_i == SHIFT_RIGHT) begin
      y_o = b_i >> s_i;
    end else begin
      y_o = b_i << s_i;
    end
  end

endmodule

// File: rtl/alu.sv
// Registered 32-bit ALU: combinational op decode feeding a result register with
// synchronous reset, giving one cycle of latency from operands to C.
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUop,
  input  logic [4:0]  S,
  output logic [31:0] C
);

  logic [31:0] shiftResult;
  logic        shiftDir;
  logic [31:0] result_d;
  logic [31:0] result_q;

  assign shiftDir = (ALUop == ALU_SRL) ? SHIFT_RIGHT : SHIFT_LEFT;

  alu_shifter u_shifter (
    .b_i  (B),
    .s_i  (S),
    .dir_i(shiftDir),
    .y_o  (shiftResult)
  );

  // Shifter output is only selected for shift ops, so a junk S cannot reach C otherwise.
  always_comb begin
    result_d = 32'h0000_0000;
    case (ALUop)
      ALU_ADD: result_d = A + B;
      ALU_SUB: result_d = A - B;
      ALU_AND: result_d = A & B;
      ALU_OR:  result_d = A | B;
      ALU_XOR: result_d = A ^ B;
      ALU_LUI: result_d = {B[15:0], 16'h0000};
      ALU_SLL: result_d = shiftResult;
      ALU_SRL: result_d = shiftResult;
      default: result_d = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= 32'h0000_0000;
    end else begin
      result_q <= result_d;
    end
  end

  assign C = result_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: each driven cycle pushes its expected result, and
// the feature task pops and compares it once the registered output settles.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUop;
  logic [4:0]  S;
  logic [31:0] C;

  int total = 0;
  int bad   = 0;
  logic [31:0] expQ[$];
  logic [31:0] expected;

  alu dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .B    (B),
    .ALUop(ALUop),
    .S    (S),
    .C    (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: subtraction via two's complement, shifts via bit loops.
  function automatic logic [31:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op, input logic [4:0] s);
    logic [31:0] r;
    r = 32'h0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a + (~b) + 32'd1;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = b * 32'h0001_0000;
      3'd6: for (int i = 0; i < 32; i++) r[i] = (i >= int'(s)) ? b[i - int'(s)] : 1'b0;
      3'd7: for (int i = 0; i < 32; i++) r[i] = (i + int'(s) <= 31) ? b[i + int'(s)] : 1'b0;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Drive one cycle of inputs, record the expected result, advance past the edge.
  task automatic applyStimulus(input logic rst, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] s, input logic [31:0] exp);
    reset = rst;
    ALUop = op;
    A     = a;
    B     = b;
    S     = s;
    expQ.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic popExpected(output logic [31:0] e, output bit ok);
    if (expQ.size() == 0) begin
      e  = 32'h0;
      ok = 1'b0;
    end else begin
      e  = expQ.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 3'($urandom), $urandom, $urandom, 5'($urandom), 32'h0);
      popExpected(expected, ok);
      total++;
      if (!ok || C !== expected) begin
        bad++;
        $display("[TB] FAIL reset_%0d: C=%h expected=%h", i, C, expected);
      end
    end
    applyStimulus(1'b0, 3'b000, 32'd5, 32'd7, 5'($urandom), 32'h0000_000C);
    popExpected(expected, ok);
    total++;
    if (!ok || C !== expected) begin
      bad++;
      $display("[TB] FAIL reset_release_add: C=%h expected=%h", C, expected);
    end
  endtask

  task automatic test_sll();
    logic [31:0] bv[4]  = '{32'hF000_0003, 32'hF000_0003, 32'hF000_0003, 32'h0000_1111};
    logic [4:0]  sv[4]  = '{5'd1, 5'd0, 5'd4, 5'd4};
    logic [31:0] ev[4]  = '{32'hE000_0006, 32'hF000_0003, 32'h0000_0030, 32'h0001_1110};
    bit ok;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 3'b110, 32'h0, bv[i], sv[i], ev[i]);
      popExpected(expected, ok);
      total++;
      if (!ok || C !== expected) begin
        bad++;
        $display("[TB] FAIL sll_step%0d: C=%h expected=%h", i, C, expected);
      end
    end
  endtask

  task automatic test_arith_wrap();
    bit ok;
    applyStimulus(1'b0, 3'b000, 32'hFFFF_FFFF, 32'h1, 5'd9, 32'h0000_0000);
    popExpected(expected, ok);
    total++;
    if (!ok || C !== expected) begin
      bad++;
      $display("[TB] FAIL add_wrap: C=%h expected=%h", C, expected);
    end
    applyStimulus(1'b0, 3'b001, 32'h0, 32'h1, 5'd17, 32'hFFFF_FFFF);
    popExpected(expected, ok);
    total++;
    if (!ok || C !== expected) begin
      bad++;
      $display("[TB] FAIL sub_wrap: C=%h expected=%h", C, expected);
    end
  endtask

  task automatic test_logic_lui();
    logic [2:0]  ov[4] = '{3'b010, 3'b011, 3'b100, 3'b101};
    logic [31:0] ev[4] = '{32'h00F0_0204, 32'hFFF0_BBFD, 32'hFF00_B9F9, 32'hABCD_0000};
    bit ok;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, ov[i], 32'hF0F0_1234, 32'h0FF0_ABCD, 5'($urandom), ev[i]);
      popExpected(expected, ok);
      total++;
      if (!ok || C !== expected) begin
        bad++;
        $display("[TB] FAIL logic_op%0d: C=%h expected=%h", ov[i], C, expected);
      end
    end
  endtask

  task automatic test_srl();
    bit ok;
    applyStimulus(1'b0, 3'b111, 32'hDEAD_BEEF, 32'h8000_0000, 5'd31, 32'h0000_0001);
    popExpected(expected, ok);
    total++;
    if (!ok || C !== expected) begin
      bad++;
      $display("[TB] FAIL srl_s31: C=%h expected=%h", C, expected);
    end
    applyStimulus(1'b0, 3'b111, 32'h1234_5678, 32'h8000_0000, 5'd0, 32'h8000_0000);
    popExpected(expected, ok);
    total++;
    if (!ok || C !== expected) begin
      bad++;
      $display("[TB] FAIL srl_s0: C=%h expected=%h", C, expected);
    end
  endtask

  task automatic test_back_to_back();
    logic        rv[3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  ov[3] = '{3'b000, 3'b000, 3'b011};
    logic [31:0] av[3] = '{32'd1, 32'd1, 32'd0};
    logic [31:0] bv[3] = '{32'd1, 32'd1, 32'd3};
    logic [31:0] ev[3] = '{32'h2, 32'h0, 32'h3};
    bit ok;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(rv[i], ov[i], av[i], bv[i], 5'd0, ev[i]);
      popExpected(expected, ok);
      total++;
      if (!ok || C !== expected) begin
        bad++;
        $display("[TB] FAIL b2b_step%0d: C=%h expected=%h", i, C, expected);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [4:0]  s;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = 3'($urandom_range(0, 7));
      s  = 5'($urandom_range(0, 31));
      applyStimulus(1'b0, op, a, b, s, refModel(a, b, op, s));
      popExpected(expected, ok);
      total++;
      if (!ok || C !== expected) begin
        bad++;
        $display("[TB] FAIL random_%0d op=%0d a=%h b=%h s=%0d: C=%h expected=%h",
                 i, op, a, b, s, C, expected);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    A     = 32'h0;
    B     = 32'h0;
    ALUop = 3'b000;
    S     = 5'd0;
    @(negedge clk);
    test_reset();
    test_sll();
    test_arith_wrap();
    test_logic_lui();
    test_srl();
    test_back_to_back();
    test_random();
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: left=%0d required=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
